// File: rtl/vend_pkg.sv
// Shared vending definitions: chocolate codes and dispenser states.
// The upstream coin-counting FSM imports this package as well.
package vend_pkg;

  localparam logic [1:0] CHOCO_NONE  = 2'b00;
  localparam logic [1:0] CHOCO_ONE   = 2'b01;
  localparam logic [1:0] CHOCO_TWO   = 2'b10;
  localparam logic [1:0] CHOCO_THREE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_REFUND = 2'd2,
    ST_GAP    = 2'd3
  } disp_state_e;

  // Motor select: bit k-1 drives the motor for chocolate type k.
  function automatic logic [2:0] choco_onehot(input logic [1:0] code);
    logic [2:0] oh;
    case (code)
      CHOCO_ONE:   oh = 3'b001;
      CHOCO_TWO:   oh = 3'b010;
      CHOCO_THREE: oh = 3'b100;
      default:     oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/choco_dispenser_stock_counter.sv
// Per-type stock counter: reload on load, saturating decrement on dec.
// A load and a dec in the same cycle leave STOCK_INIT-1 (reload first, then sale).
module stock_counter #(
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               dec,
  output logic [STOCK_W-1:0] count,
  output logic               empty
);

  logic [STOCK_W-1:0] count_d;
  logic [STOCK_W-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (load && dec) begin
      count_d = STOCK_W'(STOCK_INIT - 1);
    end else if (load) begin
      count_d = STOCK_W'(STOCK_INIT);
    end else if (dec && (count_q != {STOCK_W{1'b0}})) begin
      count_d = count_q - STOCK_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= STOCK_W'(STOCK_INIT);
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign empty = (count_q == {STOCK_W{1'b0}});

endmodule

// File: rtl/choco_dispenser.sv
// Chocolate dispenser: checks per-type stock, pulses the matching motor or
// refunds the coin, then cools down; codes arriving while busy are flagged.
module choco_dispenser
  import vend_pkg::*;
#(
  parameter int MOTOR_CYCLES = 8,
  parameter int GAP_CYCLES   = 2,
  parameter int STOCK_INIT   = 4,
  parameter int STOCK_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] choco,
  input  logic       restock,
  output logic [2:0] motor,
  output logic [1:0] refund,
  output logic       busy,
  output logic [2:0] sold_out,
  output logic       missed
);

  localparam int CNT_MAX = (MOTOR_CYCLES > GAP_CYCLES) ? MOTOR_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  disp_state_e        state_d, state_q;
  logic [1:0]         code_d, code_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic [2:0]         motor_d, motor_q;
  logic [1:0]         refund_d, refund_q;
  logic               busy_d, busy_q;
  logic [2:0]         sold_out_d, sold_out_q;
  logic               missed_d, missed_q;

  logic [2:0]         dec_s;
  logic [2:0]         empty_s;
  logic [STOCK_W-1:0] count_s [3];
  logic               sel_avail_s;

  for (genvar i = 0; i < 3; i++) begin : g_stock
    stock_counter #(
      .STOCK_W   (STOCK_W),
      .STOCK_INIT(STOCK_INIT)
    ) u_stock (
      .clk  (clk),
      .reset(reset),
      .load (restock),
      .dec  (dec_s[i]),
      .count(count_s[i]),
      .empty(empty_s[i])
    );
  end

  // A same-cycle restock makes a sold-out type available again.
  always_comb begin
    sel_avail_s = 1'b0;
    case (choco)
      CHOCO_ONE:   sel_avail_s = restock || (count_s[0] != {STOCK_W{1'b0}});
      CHOCO_TWO:   sel_avail_s = restock || (count_s[1] != {STOCK_W{1'b0}});
      CHOCO_THREE: sel_avail_s = restock || (count_s[2] != {STOCK_W{1'b0}});
      default:     sel_avail_s = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    motor_d  = 3'b000;
    refund_d = 2'b00;
    dec_s    = 3'b000;
    case (state_q)
      ST_IDLE: begin
        if (choco != CHOCO_NONE) begin
          code_d = choco;
          if (sel_avail_s) begin
            dec_s   = choco_onehot(choco);
            motor_d = choco_onehot(choco);
            cnt_d   = CNT_W'(MOTOR_CYCLES - 1);
            state_d = ST_VEND;
          end else begin
            refund_d = choco;
            state_d  = ST_REFUND;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_VEND: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
          state_d = ST_GAP;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          motor_d = choco_onehot(code_q);
        end
      end
      ST_REFUND: begin
        cnt_d   = CNT_W'(GAP_CYCLES - 1);
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d     = (state_d != ST_IDLE);
    missed_d   = (state_q != ST_IDLE) && (choco != CHOCO_NONE);
    sold_out_d = empty_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      code_q     <= CHOCO_NONE;
      cnt_q      <= {CNT_W{1'b0}};
      motor_q    <= 3'b000;
      refund_q   <= 2'b00;
      busy_q     <= 1'b0;
      sold_out_q <= 3'b000;
      missed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      cnt_q      <= cnt_d;
      motor_q    <= motor_d;
      refund_q   <= refund_d;
      busy_q     <= busy_d;
      sold_out_q <= sold_out_d;
      missed_q   <= missed_d;
    end
  end

  assign motor    = motor_q;
  assign refund   = refund_q;
  assign busy     = busy_q;
  assign sold_out = sold_out_q;
  assign missed   = missed_q;

endmodule

// File: tb/tb_choco_dispenser.sv
// Self-checking bench for choco_dispenser: directed scenarios plus random
// traffic, all compared against a timeline-based reference model.
module tb_choco_dispenser;

  localparam int M  = 8;
  localparam int G  = 2;
  localparam int SI = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       restock = 1'b0;
  logic [1:0] choco = 2'b00;
  logic [2:0] motor, sold_out;
  logic [1:0] refund;
  logic       busy, missed;

  int checks = 0;
  int failures = 0;

  // Reference model: stock per type and the edge windows of the active transaction.
  int e = 0;
  int busy_last = -1000;
  int mot_first = 1;
  int mot_last = 0;
  int mot_type = 1;
  int stock[3];
  logic [2:0] exp_motor = 3'b000;
  logic [2:0] exp_sold_out = 3'b000;
  logic [1:0] exp_refund = 2'b00;
  logic       exp_busy = 1'b0;
  logic       exp_missed = 1'b0;

  wire [9:0] obs  = {motor, refund, busy, sold_out, missed};
  wire [9:0] expv = {exp_motor, exp_refund, exp_busy, exp_sold_out, exp_missed};

  choco_dispenser #(
    .MOTOR_CYCLES(M),
    .GAP_CYCLES  (G),
    .STOCK_INIT  (SI),
    .STOCK_W     (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .choco   (choco),
    .restock (restock),
    .motor   (motor),
    .refund  (refund),
    .busy    (busy),
    .sold_out(sold_out),
    .missed  (missed)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) stock[i] = SI;
    busy_last = -1000;
    mot_first = 1;
    mot_last = 0;
    exp_motor = 3'b000;
    exp_refund = 2'b00;
    exp_busy = 1'b0;
    exp_sold_out = 3'b000;
    exp_missed = 1'b0;
  endtask

  // Apply one cycle of stimulus, advance the model across the edge, settle #1 after it.
  task automatic drive(input logic [1:0] c, input logic r);
    int k;
    bit idle;
    choco = c;
    restock = r;
    @(posedge clk);
    e++;
    for (int i = 0; i < 3; i++) exp_sold_out[i] = (stock[i] == 0);
    idle = (e - 1) > busy_last;
    k = int'(c);
    exp_missed = (k != 0) && !idle;
    exp_refund = 2'b00;
    if (r) for (int i = 0; i < 3; i++) stock[i] = SI;
    if (k != 0 && idle) begin
      if (stock[k-1] > 0) begin
        stock[k-1]--;
        mot_type = k;
        mot_first = e;
        mot_last = e + M - 1;
        busy_last = e + M + G - 1;
      end else begin
        exp_refund = c;
        busy_last = e + G;
      end
    end
    exp_motor = (e >= mot_first && e <= mot_last) ? (3'b001 << (mot_type - 1)) : 3'b000;
    exp_busy = (e <= busy_last);
    #1;
    choco = 2'b00;
    restock = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    checks++;
    if (obs !== 10'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", obs, 10'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 1'b0);
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL reset_idle edge=%0d got=%b exp=%b", e, obs, expv);
      end
    end
  endtask

  task automatic test_vend_basic();
    for (int i = 0; i < 12; i++) begin
      drive((i == 0) ? 2'b10 : 2'b00, 1'b0);
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL vend_basic edge=%0d got=%b exp=%b", e, obs, expv);
      end
      checks++;
      if (motor !== ((i < M) ? 3'b010 : 3'b000)) begin
        failures++;
        $display("FAIL vend_motor i=%0d got=%b", i, motor);
      end
      checks++;
      if (busy !== (i < M + G)) begin
        failures++;
        $display("FAIL vend_busy i=%0d got=%b", i, busy);
      end
    end
  endtask

  task automatic test_sold_out();
    for (int i = 0; i < 55; i++) begin
      drive((i % 11 == 0) ? 2'b01 : 2'b00, 1'b0);
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL sold_out_seq edge=%0d got=%b exp=%b", e, obs, expv);
      end
      if (i == 44) begin
        checks++;
        if (refund !== 2'b01 || motor !== 3'b000) begin
          failures++;
          $display("FAIL sold_out_refund refund=%b motor=%b exp refund=01 motor=000", refund, motor);
        end
      end
      if (i == 34) begin
        checks++;
        if (sold_out !== 3'b001) begin
          failures++;
          $display("FAIL sold_out_flag got=%b exp=001", sold_out);
        end
      end
    end
  endtask

  task automatic test_missed();
    for (int i = 0; i < 12; i++) begin
      drive((i == 0) ? 2'b11 : ((i == 3) ? 2'b01 : 2'b00), 1'b0);
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL missed_seq edge=%0d got=%b exp=%b", e, obs, expv);
      end
      if (i == 3 || i == 4) begin
        checks++;
        if (missed !== (i == 3)) begin
          failures++;
          $display("FAIL missed_pulse i=%0d got=%b", i, missed);
        end
      end
      if (i < M) begin
        checks++;
        if (motor !== 3'b100) begin
          failures++;
          $display("FAIL missed_motor i=%0d got=%b exp=100", i, motor);
        end
      end
    end
  endtask

  task automatic test_restock_same_cycle();
    for (int i = 0; i < 45; i++) begin
      drive((i % 11 == 0) ? 2'b11 : 2'b00, (i == 33));
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL restock_seq edge=%0d got=%b exp=%b", e, obs, expv);
      end
      if (i >= 33 && i < 33 + M) begin
        checks++;
        if (motor !== 3'b100) begin
          failures++;
          $display("FAIL restock_motor i=%0d got=%b exp=100", i, motor);
        end
      end
      if (i == 34) begin
        checks++;
        if (sold_out !== 3'b000) begin
          failures++;
          $display("FAIL restock_sold_out got=%b exp=000", sold_out);
        end
      end
    end
  endtask

  task automatic test_reset_mid_vend();
    for (int i = 0; i < 4; i++) begin
      drive((i == 0) ? 2'b01 : 2'b00, 1'b0);
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL midreset_pre edge=%0d got=%b exp=%b", e, obs, expv);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (motor !== 3'b000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async motor=%b busy=%b exp 000/0", motor, busy);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive((i == 0) ? 2'b01 : 2'b00, 1'b0);
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL midreset_post edge=%0d got=%b exp=%b", e, obs, expv);
      end
      if (i < M) begin
        checks++;
        if (motor !== 3'b001) begin
          failures++;
          $display("FAIL midreset_motor i=%0d got=%b exp=001", i, motor);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 45; i++) begin
      drive((i == 0 || i == 11 || i == 22 || i == 32) ? 2'b10 : 2'b00, 1'b0);
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL b2b_seq edge=%0d got=%b exp=%b", e, obs, expv);
      end
      if (i == 11) begin
        checks++;
        if (missed !== 1'b0 || motor !== 3'b010) begin
          failures++;
          $display("FAIL b2b_legal missed=%b motor=%b exp 0/010", missed, motor);
        end
      end
      if (i == 32) begin
        checks++;
        if (missed !== 1'b1) begin
          failures++;
          $display("FAIL b2b_early missed=%b exp=1", missed);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] c;
    logic r;
    for (int i = 0; i < 600; i++) begin
      c = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      r = ($urandom_range(0, 31) == 0);
      drive(c, r);
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL random edge=%0d got=%b exp=%b", e, obs, expv);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_vend_basic();
    test_sold_out();
    test_missed();
    test_restock_same_cycle();
    test_reset_mid_vend();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
